// File: rtl/general_defs.sv
// rtl/general_defs.sv - shared word widths and pipeline control signal types
package GENERAL_DEFS;

  localparam int HALF_WORD = 16;
  localparam int WORD      = 32;

  typedef logic stall_pipeline_sig;
  typedef logic flush_pipeline_sig;

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// rtl/fetch_queue_sync_fifo.sv - synchronous FIFO with clear, full/empty and count
module sync_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_push = push_i && !full_o && !clear_i;
  assign do_pop  = pop_i && !empty_o && !clear_i;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clear_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PTR_W'(1);
      if (do_pop)  rptr_d = rptr_q + PTR_W'(1);
      if (do_push && !do_pop) count_d = count_q + CNT_W'(1);
      if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - credit-based instruction fetch queue with flush/redirect
module fetch_queue
  import GENERAL_DEFS::*;
#(
  parameter int DEPTH    = 4,
  parameter int INSTR_W  = HALF_WORD,
  parameter int ADDR_W   = WORD,
  parameter int PC_STEP  = 2,
  parameter int RESET_PC = 0
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  flush_pipeline_sig          flush_pipeline_i,
  input  logic [ADDR_W-1:0]          redirect_pc_i,
  input  stall_pipeline_sig          stall_pipeline_i,
  output logic                       imem_req_o,
  output logic [ADDR_W-1:0]          imem_addr_o,
  input  logic [INSTR_W-1:0]         imem_data_i,
  output logic                       is_valid_o,
  output logic [INSTR_W-1:0]         instruction_o,
  output logic [ADDR_W-1:0]          program_counter_o,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

  localparam int CNT_W   = $clog2(DEPTH+1);
  localparam int ENTRY_W = ADDR_W + INSTR_W;

  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]  req_pc_q;
  logic               inflight_q;
  logic [ADDR_W-1:0]  last_pc_q;
  logic [INSTR_W-1:0] last_instr_q;

  logic [ENTRY_W-1:0] head;
  logic               fifo_full, fifo_empty;
  logic [CNT_W-1:0]   count;
  logic [CNT_W:0]     credit_used;
  logic               push, pop;

  // A response still in flight already owns a slot, so it counts against the credit.
  assign credit_used = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q};
  assign imem_req_o  = !reset_i && !flush_pipeline_i && (credit_used < (CNT_W+1)'(DEPTH));
  assign imem_addr_o = fetch_pc_q;

  assign push = inflight_q && !flush_pipeline_i;
  assign pop  = is_valid_o && !stall_pipeline_i && !flush_pipeline_i;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (flush_pipeline_i)
      fetch_pc_d = redirect_pc_i;
    else if (imem_req_o)
      fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fetch_pc_q <= ADDR_W'(RESET_PC);
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= imem_req_o;
      if (imem_req_o) req_pc_q <= fetch_pc_q;
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (flush_pipeline_i),
    .push_i  (push),
    .wdata_i ({req_pc_q, imem_data_i}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count)
  );

  assign is_valid_o  = !fifo_empty;
  assign occupancy_o = count;

  // While empty the head outputs hold whatever was last presented.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_pc_q    <= '0;
      last_instr_q <= '0;
    end else if (is_valid_o) begin
      last_pc_q    <= head[ENTRY_W-1:INSTR_W];
      last_instr_q <= head[INSTR_W-1:0];
    end
  end

  assign program_counter_o = is_valid_o ? head[ENTRY_W-1:INSTR_W] : last_pc_q;
  assign instruction_o     = is_valid_o ? head[INSTR_W-1:0] : last_instr_q;

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset4, flush4, stall4;
  logic [31:0] redir4;
  logic        req4, valid4;
  logic [31:0] addr4, pc4;
  logic [15:0] data4, instr4;
  logic [2:0]  occ4;

  logic        reset8, flush8, stall8;
  logic [31:0] redir8;
  logic        req8, valid8;
  logic [31:0] addr8, pc8;
  logic [15:0] data8, instr8;
  logic [3:0]  occ8;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_queue #(.DEPTH(4)) dut (
    .clk_i(clk), .reset_i(reset4), .flush_pipeline_i(flush4), .redirect_pc_i(redir4),
    .stall_pipeline_i(stall4), .imem_req_o(req4), .imem_addr_o(addr4), .imem_data_i(data4),
    .is_valid_o(valid4), .instruction_o(instr4), .program_counter_o(pc4), .occupancy_o(occ4)
  );

  fetch_queue #(.DEPTH(8)) dut8 (
    .clk_i(clk), .reset_i(reset8), .flush_pipeline_i(flush8), .redirect_pc_i(redir8),
    .stall_pipeline_i(stall8), .imem_req_o(req8), .imem_addr_o(addr8), .imem_data_i(data8),
    .is_valid_o(valid8), .instruction_o(instr8), .program_counter_o(pc8), .occupancy_o(occ8)
  );

  // Instruction memory: one cycle latency, mem[a] = a[15:0] ^ 16'hA5A5
  always @(posedge clk) begin
    if (req4) data4 <= addr4[15:0] ^ 16'hA5A5;
    if (req8) data8 <= addr8[15:0] ^ 16'hA5A5;
  end

  function automatic logic [15:0] mem_of(input logic [31:0] a);
    return a[15:0] ^ 16'hA5A5;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start4(input logic stall);
    reset4 = 1'b1; flush4 = 1'b0; stall4 = stall; redir4 = '0;
    tick(); tick();
    reset4 = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset4 = 1'b1; flush4 = 1'b0; stall4 = 1'b0; redir4 = '0;
    tick(); tick();
    n_checks++; if (req4 !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", req4); end
    n_checks++; if (occ4 !== 3'd0) begin n_fail++; $display("FAIL reset_occ got %0d exp 0", occ4); end
    n_checks++; if (valid4 !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", valid4); end
    n_checks++; if (instr4 !== 16'h0) begin n_fail++; $display("FAIL reset_instr got %h exp 0", instr4); end
    n_checks++; if (pc4 !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h exp 0", pc4); end
    n_checks++; if (addr4 !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", addr4); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    start4(1'b0);
    n_checks++; if (req4 !== 1'b1 || addr4 !== 32'h0) begin n_fail++; $display("FAIL b2b_req0 got %b/%h exp 1/0", req4, addr4); end
    n_checks++; if (valid4 !== 1'b0) begin n_fail++; $display("FAIL b2b_valid_c1 got %b exp 0", valid4); end
    tick();
    n_checks++; if (req4 !== 1'b1 || addr4 !== 32'h2) begin n_fail++; $display("FAIL b2b_req1 got %b/%h exp 1/2", req4, addr4); end
    n_checks++; if (valid4 !== 1'b0) begin n_fail++; $display("FAIL b2b_valid_c2 got %b exp 0", valid4); end
    tick();
    n_checks++; if (valid4 !== 1'b1 || pc4 !== 32'h0 || instr4 !== 16'hA5A5) begin n_fail++; $display("FAIL b2b_first got %b/%h/%h exp 1/0/a5a5", valid4, pc4, instr4); end
    for (int k = 1; k <= 6; k++) begin
      tick();
      e = 32'(2 * k);
      n_checks++; if (valid4 !== 1'b1 || pc4 !== e || instr4 !== mem_of(e) || occ4 !== 3'd1) begin
        n_fail++; $display("FAIL b2b_stream k=%0d got %b/%h/%h/%0d exp 1/%h/%h/1", k, valid4, pc4, instr4, occ4, e, mem_of(e));
      end
    end
  endtask

  task automatic test_stall_saturate();
    logic [2:0]  exp_occ [6];
    logic        exp_req [6];
    logic [31:0] e;
    exp_occ = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    exp_req = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    start4(1'b1);
    for (int c = 0; c < 6; c++) begin
      n_checks++; if (occ4 !== exp_occ[c] || req4 !== exp_req[c]) begin
        n_fail++; $display("FAIL stall_fill c=%0d got occ %0d req %b exp occ %0d req %b", c + 1, occ4, req4, exp_occ[c], exp_req[c]);
      end
      tick();
    end
    tick(); tick();
    n_checks++; if (occ4 !== 3'd4 || req4 !== 1'b0 || pc4 !== 32'h0) begin n_fail++; $display("FAIL stall_hold got %0d/%b/%h exp 4/0/0", occ4, req4, pc4); end
    stall4 = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      e = 32'(2 * k);
      n_checks++; if (valid4 !== 1'b1 || pc4 !== e || instr4 !== mem_of(e)) begin
        n_fail++; $display("FAIL stall_drain k=%0d got %b/%h/%h exp 1/%h/%h", k, valid4, pc4, instr4, e, mem_of(e));
      end
      tick();
    end
  endtask

  task automatic test_flush();
    start4(1'b1);
    tick(); tick(); tick(); tick();
    n_checks++; if (occ4 !== 3'd3 || req4 !== 1'b0) begin n_fail++; $display("FAIL flush_pre got %0d/%b exp 3/0", occ4, req4); end
    flush4 = 1'b1; redir4 = 32'h100;
    #1;
    n_checks++; if (req4 !== 1'b0) begin n_fail++; $display("FAIL flush_noreq got %b exp 0", req4); end
    tick();
    flush4 = 1'b0;
    #1;
    n_checks++; if (occ4 !== 3'd0 || valid4 !== 1'b0) begin n_fail++; $display("FAIL flush_clear got %0d/%b exp 0/0", occ4, valid4); end
    n_checks++; if (pc4 !== 32'h0 || instr4 !== 16'hA5A5) begin n_fail++; $display("FAIL flush_hold got %h/%h exp 0/a5a5", pc4, instr4); end
    n_checks++; if (req4 !== 1'b1 || addr4 !== 32'h100) begin n_fail++; $display("FAIL flush_redir got %b/%h exp 1/100", req4, addr4); end
    tick();
    n_checks++; if (valid4 !== 1'b0 || occ4 !== 3'd0) begin n_fail++; $display("FAIL flush_stale got %b/%0d exp 0/0", valid4, occ4); end
    tick();
    n_checks++; if (valid4 !== 1'b1 || pc4 !== 32'h100 || instr4 !== 16'hA4A5) begin n_fail++; $display("FAIL flush_head got %b/%h/%h exp 1/100/a4a5", valid4, pc4, instr4); end
  endtask

  task automatic test_flush_stall_full();
    start4(1'b1);
    for (int c = 0; c < 7; c++) tick();
    n_checks++; if (occ4 !== 3'd4) begin n_fail++; $display("FAIL fsf_full got %0d exp 4", occ4); end
    flush4 = 1'b1; redir4 = 32'h100;
    tick();
    flush4 = 1'b0;
    #1;
    n_checks++; if (occ4 !== 3'd0 || req4 !== 1'b1 || addr4 !== 32'h100) begin n_fail++; $display("FAIL fsf_clear got %0d/%b/%h exp 0/1/100", occ4, req4, addr4); end
    tick(); tick();
    n_checks++; if (valid4 !== 1'b1 || pc4 !== 32'h100 || occ4 !== 3'd1) begin n_fail++; $display("FAIL fsf_head got %b/%h/%0d exp 1/100/1", valid4, pc4, occ4); end
  endtask

  task automatic test_double_flush();
    logic [31:0] e;
    start4(1'b0);
    tick(); tick(); tick(); tick();
    flush4 = 1'b1; redir4 = 32'h40;
    #1;
    n_checks++; if (req4 !== 1'b0) begin n_fail++; $display("FAIL dflush_req1 got %b exp 0", req4); end
    tick();
    redir4 = 32'h80;
    #1;
    n_checks++; if (req4 !== 1'b0 || occ4 !== 3'd0) begin n_fail++; $display("FAIL dflush_req2 got %b/%0d exp 0/0", req4, occ4); end
    tick();
    flush4 = 1'b0;
    #1;
    n_checks++; if (req4 !== 1'b1 || addr4 !== 32'h80) begin n_fail++; $display("FAIL dflush_addr got %b/%h exp 1/80", req4, addr4); end
    tick();
    n_checks++; if (valid4 !== 1'b0) begin n_fail++; $display("FAIL dflush_gap got %b exp 0", valid4); end
    for (int k = 0; k < 4; k++) begin
      tick();
      e = 32'h80 + 32'(2 * k);
      n_checks++; if (valid4 !== 1'b1 || pc4 !== e || instr4 !== mem_of(e)) begin
        n_fail++; $display("FAIL dflush_stream k=%0d got %b/%h/%h exp 1/%h/%h", k, valid4, pc4, instr4, e, mem_of(e));
      end
    end
  endtask

  task automatic test_midstream_reset();
    start4(1'b0);
    for (int c = 0; c < 5; c++) tick();
    reset4 = 1'b1;
    #1;
    n_checks++; if (req4 !== 1'b0) begin n_fail++; $display("FAIL mreset_req got %b exp 0", req4); end
    tick();
    n_checks++; if (occ4 !== 3'd0 || valid4 !== 1'b0 || instr4 !== 16'h0 || pc4 !== 32'h0) begin
      n_fail++; $display("FAIL mreset_state got %0d/%b/%h/%h exp 0/0/0/0", occ4, valid4, instr4, pc4);
    end
    reset4 = 1'b0;
    #1;
    n_checks++; if (req4 !== 1'b1 || addr4 !== 32'h0) begin n_fail++; $display("FAIL mreset_restart got %b/%h exp 1/0", req4, addr4); end
    tick(); tick();
    n_checks++; if (valid4 !== 1'b1 || pc4 !== 32'h0 || instr4 !== 16'hA5A5) begin n_fail++; $display("FAIL mreset_head got %b/%h/%h exp 1/0/a5a5", valid4, pc4, instr4); end
  endtask

  task automatic test_depth8_wrap();
    logic [31:0] e;
    reset8 = 1'b1; flush8 = 1'b0; stall8 = 1'b1; redir8 = '0;
    tick(); tick();
    reset8 = 1'b0;
    for (int c = 0; c < 12; c++) tick();
    n_checks++; if (occ8 !== 4'd8 || req8 !== 1'b0 || pc8 !== 32'h0) begin n_fail++; $display("FAIL d8_full got %0d/%b/%h exp 8/0/0", occ8, req8, pc8); end
    stall8 = 1'b0;
    #1;
    for (int k = 0; k < 24; k++) begin
      e = 32'(2 * k);
      n_checks++; if (valid8 !== 1'b1 || pc8 !== e || instr8 !== mem_of(e)) begin
        n_fail++; $display("FAIL d8_wrap k=%0d got %b/%h/%h exp 1/%h/%h", k, valid8, pc8, instr8, e, mem_of(e));
      end
      tick();
    end
  endtask

  initial begin
    reset4 = 1'b1; flush4 = 1'b0; stall4 = 1'b0; redir4 = '0;
    reset8 = 1'b1; flush8 = 1'b0; stall8 = 1'b0; redir8 = '0;
    test_reset();
    test_back_to_back();
    test_stall_saturate();
    test_flush();
    test_flush_stall_full();
    test_double_flush();
    test_midstream_reset();
    test_depth8_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
